// File: rtl/key_event_irq.sv
// Memory-mapped 8-key input slave: synchronise, debounce, latch sticky press events, raise maskable IRQ.
// Register reads are combinational; writes and all state updates occur on the rising clk edge.
module key_event_irq #(
    parameter int DB_CNT     = 250000,
    parameter int CNT_W      = 18,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  user_key,
    input  logic [1:0]  addr,
    input  logic        WE,
    input  logic [31:0] din,
    output logic [31:0] dataOut,
    output logic        IRQ
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT - 1);

    localparam logic [1:0] A_CTRL  = 2'd0;
    localparam logic [1:0] A_STATE = 2'd1;
    localparam logic [1:0] A_EVENT = 2'd2;

    logic [7:0]       key_norm;
    logic [7:0]       sync1_q, sync2_q;
    logic [7:0]       state_q, state_d;
    logic [7:0]       event_q, event_d;
    logic [7:0]       mask_q, mask_d;
    logic             ie_q, ie_d;
    logic [CNT_W-1:0] cnt_q [8];
    logic [CNT_W-1:0] cnt_d [8];
    logic [7:0]       press;
    logic [7:0]       clr_mask;
    logic             wr_ctrl, wr_event;
    logic             unused_din;

    // Normalise so that 1 always means pressed; reset value 0 is therefore "not pressed".
    assign key_norm = ACTIVE_LOW ? ~user_key : user_key;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= key_norm;
            sync2_q <= sync1_q;
        end
    end

    always_comb begin
        cnt_d   = '{default: '0};
        state_d = state_q;
        for (int i = 0; i < 8; i++) begin
            if (sync2_q[i] != state_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    state_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign press    = state_d & ~state_q;
    assign wr_ctrl  = WE && (addr == A_CTRL);
    assign wr_event = WE && (addr == A_EVENT);
    assign clr_mask = wr_event ? din[7:0] : 8'h00;

    always_comb begin
        ie_d    = ie_q;
        mask_d  = mask_q;
        if (wr_ctrl) begin
            ie_d   = din[0];
            mask_d = din[15:8];
        end
        // A press on the same edge as its W1C clear must survive.
        event_d = (event_q & ~clr_mask) | press;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            event_q <= '0;
            mask_q  <= '0;
            ie_q    <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            event_q <= event_d;
            mask_q  <= mask_d;
            ie_q    <= ie_d;
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign IRQ = ie_q & (|(event_q & mask_q));

    always_comb begin
        dataOut = 32'h0;
        case (addr)
            A_CTRL:  dataOut = {16'h0, mask_q, 7'h0, ie_q};
            A_STATE: dataOut = {24'h0, state_q};
            A_EVENT: dataOut = {24'h0, event_q};
            default: dataOut = 32'h0;
        endcase
    end

    assign unused_din = ^din[31:16];

endmodule

// File: doc/key_event_irq.md
Name: key_event_irq

Overview:
Memory-mapped user-key input device that sits on the bridge as a slave and drives a CPU hardware interrupt line, such as the spare HWInt[4]. It synchronises and debounces the 8 raw push-buttons and latches sticky press events. It raises a maskable IRQ, so software no longer has to poll the raw key register. Register access matches the timer slave: word address on addr[3:2], a single-cycle write enable, and combinational read data.

Parameters:
DB_CNT, 250000, number of consecutive clk cycles a synchronised key level must differ from the debounced level before it is accepted (10 ms at 25 MHz); legal range 2..2^CNT_W-1.
CNT_W, 18, width of each per-key debounce counter.
ACTIVE_LOW, 1, 1 = raw key reads 0 when pressed; 0 = raw key reads 1 when pressed.

Ports:
clk  input  1  system clock; all state updates on its rising edge.
reset  input  1  synchronous, active-high reset.
user_key  input  8  raw asynchronous push-button levels.
addr  input  2  register word select, driven from DEV_Addr[3:2].
WE  input  1  write strobe from bridge; one-cycle write.
din  input  32  write data.
dataOut  output  32  read data; combinational from addr and registers.
IRQ  output  1  interrupt request, level, active-high.

Behaviour:
- Register map (addr):
  - 0 = CTRL, RW. Bit0 IE, bits[15:8] MASK, other bits read 0.
  - 1 = STATE, RO. Debounced key levels, bit=1 means pressed, bits[31:8]=0.
  - 2 = EVENT, RW1C. Sticky press flags, bits[31:8]=0.
  - 3 = reserved. Reads 0, writes ignored.
- Writes to STATE have no effect.
- Reset, applied on the clk edge with reset=1:
  - CTRL=0, STATE=0, EVENT=0, all counters=0.
  - Both synchroniser stages = inactive level, so the synchronised value reads "not pressed".
  - IRQ=0; dataOut follows the reset register values.
  - Reset overrides WE and any in-flight debounce; a partial count is discarded.
- Input path per key:
  - Polarity normalise: pressed→1.
  - Two-flop synchroniser producing sync[i].
- Debounce per key i, with counter cnt[i]:
  - sync[i]==STATE[i]: cnt[i]<=0.
  - sync[i]!=STATE[i] and cnt[i]<DB_CNT-1: cnt[i]<=cnt[i]+1.
  - sync[i]!=STATE[i] and cnt[i]==DB_CNT-1: STATE[i]<=sync[i], cnt[i]<=0.
  - Any glitch back to STATE[i] restarts the count from 0.
- Latency: a clean raw transition is reflected in STATE exactly DB_CNT+2 cycles after the first clk edge that samples the new raw level.
- Press event: on the edge where STATE[i] goes 0→1, EVENT[i]<=1. Release (1→0) sets nothing.
- EVENT write (WE=1, addr=2): for each bit with din[i]=1, EVENT[i]<=0; bits with din[i]=0 are unchanged.
- Same-edge conflict: if a new press is detected on bit i in the same cycle as a W1C of bit i, set wins and EVENT[i]=1 after the edge.
- IRQ = IE & |(EVENT & MASK). Combinational from registers, so it asserts in the same cycle EVENT/CTRL update and deasserts the cycle after the clearing write.
- Changing MASK or IE never modifies EVENT. Unmasking a pending flag raises IRQ immediately after the CTRL write edge.
- dataOut reflects register contents after the most recent edge; a read in the same cycle as a write returns the old value.
- Keys are independent; simultaneous presses on multiple keys set multiple EVENT bits on the same edge.

Test Plan:
1. DB_CNT=4, ACTIVE_LOW=1, reset released; drive user_key[0]=0 and hold → STATE=32'h1 exactly 6 cycles later, EVENT=32'h1, IRQ stays 0 (IE=0).
2. Bounce: user_key[3] low for 3 cycles, high 1 cycle, low 3 cycles, then high → STATE and EVENT remain 0 throughout.
3. Write CTRL=32'h0000_0101, then press key0 → IRQ=1 on the edge EVENT[0] sets. Press key1 with MASK=0x01 → EVENT=0x3, IRQ unaffected by bit1.
4. With EVENT=0x3, write EVENT din=0x1 → EVENT=0x2, IRQ=0. Then write din=0x2 in the same cycle key1 re-press completes → EVENT bit1 stays 1.
5. Release key0 after press → STATE[0] returns 0 after DB_CNT+2 cycles, EVENT unchanged. Read addr=3 → 0; write STATE → no change.
6. Assert reset while key2's counter is at 2 → after the reset edge, all registers 0 and IRQ=0. The key held pressed is re-accepted DB_CNT+2 cycles after reset release.
